// File: rtl/xike_pkg.sv
// Shared constants for the xike acquisition path, plus the sequencing state type
// and a small popcount helper used by the stream combiner.
package xike_pkg;

    localparam int XIKE_DATA_W      = 16;
    localparam int XIKE_CH_PER_CHIP = 32;
    localparam int XIKE_MAX_STREAMS = 16;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_RESYNC = 1'b1
    } rc_state_e;

    function automatic logic [4:0] ones_cnt(input logic [XIKE_MAX_STREAMS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < XIKE_MAX_STREAMS; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/raw_comb_sfifo.sv
// Single-clock first-word-fall-through FIFO. Head word is combinational from storage;
// flush empties it, and a write on the flush cycle becomes the only word.
module raw_comb_sfifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       cnt_q;
    logic              do_wr;
    logic              do_rd;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Flush frees every slot, so a write alongside it never sees full.
    assign do_wr = wr && (flush || !full);
    assign do_rd = rd && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= do_wr ? AW'(1) : '0;
            cnt_q    <= do_wr ? (AW+1)'(1) : '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[flush ? '0 : wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/raw_comb_nstream.sv
// N-stream raw combiner: demuxes one-hot-tagged words into per-stream FWFT buffers and
// emits one wide beat when all enabled streams hold data. Optional RAW_COMB_RESYNC_EN.
module raw_comb_nstream
    import xike_pkg::*;
#(
    parameter int N_STREAMS     = 5,
    parameter int DATA_W        = XIKE_DATA_W,
    parameter int DEPTH         = 16,
    parameter int CH_PER_STREAM = XIKE_CH_PER_CHIP
) (
    input  logic                             bus_clk,
    input  logic                             xike_reset,
    input  logic [N_STREAMS-1:0]             in_streamno,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             in_first,
    input  logic [N_STREAMS-1:0]             stream_en,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [N_STREAMS*DATA_W-1:0]      out_data,
    output logic [$clog2(CH_PER_STREAM)-1:0] out_chno,
    output logic                             out_sof,
    input  logic                             ovf_clr,
    output logic [N_STREAMS-1:0]             ovf_flag,
    output logic                             onehot_err
);

    localparam int CW = $clog2(CH_PER_STREAM);

    logic [XIKE_MAX_STREAMS-1:0] req_pad;
    logic [4:0]                  req_cnt;
    logic                        onehot;
    logic                        multi;
    logic [N_STREAMS-1:0]        sel;
    logic [N_STREAMS-1:0]        wr;
    logic [N_STREAMS-1:0]        rd;
    logic [N_STREAMS-1:0]        full;
    logic [N_STREAMS-1:0]        empty;
    logic [N_STREAMS-1:0]        ovf_ev;
    logic [DATA_W-1:0]           head [N_STREAMS];
    logic                        resync;
    logic                        fire;
    logic [CW-1:0]               chno_q;
    logic [N_STREAMS-1:0]        ovf_q;
    logic                        oh_err_q;

    assign req_pad = XIKE_MAX_STREAMS'(in_streamno);
    assign req_cnt = ones_cnt(req_pad);
    assign onehot  = (req_cnt == 5'd1);
    assign multi   = (req_cnt > 5'd1);
    assign sel     = in_streamno & stream_en & {N_STREAMS{onehot}};

`ifdef RAW_COMB_RESYNC_EN
    rc_state_e state_q;
    rc_state_e state_d;

    always_ff @(posedge bus_clk or posedge xike_reset) begin
        if (xike_reset) state_q <= ST_RUN;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (|ovf_ev) state_d = ST_RESYNC;
            ST_RESYNC: if (in_first && |sel) state_d = ST_RUN;
        endcase
    end

    assign resync = (state_q == ST_RESYNC);
`else
    logic unused_in_first;
    assign unused_in_first = in_first;
    assign resync          = 1'b0;
`endif

    // While resyncing the buffers are held flushed; only a sample-cycle start may enter.
    always_comb begin
        wr     = '0;
        ovf_ev = '0;
        for (int k = 0; k < N_STREAMS; k++) begin
            wr[k]     = resync ? (sel[k] && in_first) : (sel[k] && !full[k]);
            ovf_ev[k] = !resync && sel[k] && full[k];
        end
    end

    assign out_valid = (|stream_en) && (&(~empty | ~stream_en)) && !resync;
    assign fire      = out_valid && out_ready;
    assign rd        = {N_STREAMS{fire}} & stream_en;

    for (genvar k = 0; k < N_STREAMS; k++) begin : g_lane
        raw_comb_sfifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (bus_clk),
            .rst     (xike_reset),
            .wr      (wr[k]),
            .wr_data (in_data),
            .rd      (rd[k]),
            .flush   (resync),
            .rd_data (head[k]),
            .full    (full[k]),
            .empty   (empty[k])
        );
    end

    // Stream 0 lands in the MSBs; lanes are zeroed when disabled or when no beat is offered.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N_STREAMS; k++) begin
            if (out_valid && stream_en[k]) begin
                out_data[(N_STREAMS-1-k)*DATA_W +: DATA_W] = head[k];
            end
        end
    end

    always_ff @(posedge bus_clk or posedge xike_reset) begin
        if (xike_reset) begin
            chno_q   <= '0;
            ovf_q    <= '0;
            oh_err_q <= 1'b0;
        end else begin
            if (resync)    chno_q <= '0;
            else if (fire) chno_q <= chno_q + 1'b1;
            ovf_q    <= (ovf_clr ? '0 : ovf_q) | ovf_ev;
            oh_err_q <= (oh_err_q && !ovf_clr) || multi;
        end
    end

    assign out_chno   = chno_q;
    assign out_sof    = out_valid && (chno_q == '0);
    assign ovf_flag   = ovf_q;
    assign onehot_err = oh_err_q;

endmodule

// File: tb/tb_raw_comb_nstream.sv
// Self-checking bench for raw_comb_nstream (N=5): queue-based reference model compared
// every cycle, directed scenarios pinned with literals, then randomized traffic.
module tb_raw_comb_nstream;

    localparam int N  = 5;
    localparam int W  = 16;
    localparam int D  = 16;
    localparam int CH = 32;
    localparam int CW = 5;
    localparam int NW = N * W;

    logic          bus_clk = 1'b0;
    logic          xike_reset;
    logic [N-1:0]  in_streamno;
    logic [W-1:0]  in_data;
    logic          in_first;
    logic [N-1:0]  stream_en;
    logic          out_ready;
    logic          out_valid;
    logic [NW-1:0] out_data;
    logic [CW-1:0] out_chno;
    logic          out_sof;
    logic          ovf_clr;
    logic [N-1:0]  ovf_flag;
    logic          onehot_err;

    always #5 bus_clk = ~bus_clk;

    raw_comb_nstream #(
        .N_STREAMS     (N),
        .DATA_W        (W),
        .DEPTH         (D),
        .CH_PER_STREAM (CH)
    ) dut (
        .bus_clk     (bus_clk),
        .xike_reset  (xike_reset),
        .in_streamno (in_streamno),
        .in_data     (in_data),
        .in_first    (in_first),
        .stream_en   (stream_en),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_chno    (out_chno),
        .out_sof     (out_sof),
        .ovf_clr     (ovf_clr),
        .ovf_flag    (ovf_flag),
        .onehot_err  (onehot_err)
    );

    int errors = 0;
    int checks = 0;
    int dut_beats = 0;

    logic [W-1:0] mq [N][$];
    int           m_chno;
    logic [N-1:0] m_ovf;
    logic         m_oh;
    bit           m_resync;

    task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        if (stream_en == '0 || m_resync) return 1'b0;
        for (int k = 0; k < N; k++)
            if (stream_en[k] && mq[k].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NW-1:0] m_data();
        logic [NW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            if (stream_en[k]) r[(N-1-k)*W +: W] = mq[k][0];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) mq[k].delete();
        m_chno   = 0;
        m_ovf    = '0;
        m_oh     = 1'b0;
        m_resync = 1'b0;
    endtask

    task automatic compare();
        bit v;
        v = m_valid();
        check("out_valid", NW'(out_valid), NW'(v));
        check("out_sof", NW'(out_sof), NW'(v && m_chno == 0));
        check("ovf_flag", NW'(ovf_flag), NW'(m_ovf));
        check("onehot_err", NW'(onehot_err), NW'(m_oh));
        if (v) begin
            check("out_data", out_data, m_data());
            check("out_chno", NW'(out_chno), NW'(m_chno));
        end
    endtask

    task automatic m_update();
        int           pc;
        bit           fire;
        logic [N-1:0] sel;
        logic [N-1:0] ev;
        pc   = $countones(in_streamno);
        fire = m_valid() && out_ready;
        sel  = (pc == 1) ? (in_streamno & stream_en) : '0;
        ev   = '0;
        if (m_resync) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            m_chno = 0;
            if (in_first && sel != '0) begin
                for (int k = 0; k < N; k++) if (sel[k]) mq[k].push_back(in_data);
                m_resync = 1'b0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (sel[k]) begin
                    if (mq[k].size() >= D) ev[k] = 1'b1;
                    else mq[k].push_back(in_data);
                end
            end
            if (fire) begin
                for (int k = 0; k < N; k++) if (stream_en[k]) void'(mq[k].pop_front());
                m_chno = (m_chno + 1) % CH;
            end
`ifdef RAW_COMB_RESYNC_EN
            if (ev != '0) m_resync = 1'b1;
`endif
        end
        m_ovf = (ovf_clr ? '0 : m_ovf) | ev;
        m_oh  = (m_oh && !ovf_clr) || (pc > 1);
    endtask

    // One bus cycle: drive at negedge, compare, advance model at the edge, return to negedge.
    task automatic step(input logic [N-1:0] sn, input logic [W-1:0] d, input logic f,
                        input logic rdy, input logic clr);
        in_streamno = sn;
        in_data     = d;
        in_first    = f;
        out_ready   = rdy;
        ovf_clr     = clr;
        #1;
        compare();
        if (out_valid && out_ready) dut_beats++;
        @(posedge bus_clk);
        m_update();
        @(negedge bus_clk);
    endtask

    task automatic do_reset(input logic [N-1:0] en);
        xike_reset  = 1'b1;
        stream_en   = en;
        in_streamno = '0;
        in_data     = '0;
        in_first    = 1'b0;
        out_ready   = 1'b0;
        ovf_clr     = 1'b0;
        #1;
        check("rst_out_valid", NW'(out_valid), NW'(0));
        check("rst_out_data", out_data, NW'(0));
        check("rst_out_chno", NW'(out_chno), NW'(0));
        check("rst_out_sof", NW'(out_sof), NW'(0));
        check("rst_ovf_flag", NW'(ovf_flag), NW'(0));
        check("rst_onehot_err", NW'(onehot_err), NW'(0));
        model_clear();
        dut_beats = 0;
        @(posedge bus_clk);
        @(negedge bus_clk);
        xike_reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] en;
        int           r;
        logic [N-1:0] sn;

        xike_reset  = 1'b1;
        stream_en   = '1;
        in_streamno = '0;
        in_data     = '0;
        in_first    = 1'b0;
        out_ready   = 1'b0;
        ovf_clr     = 1'b0;
        @(negedge bus_clk);

        // 32 full rounds, ready held high
        do_reset('1);
        for (int ch = 0; ch < 32; ch++) begin
            for (int k = 0; k < N; k++) begin
                step(N'(1 << k), W'(ch * 16 + k), k == 0, 1'b1, 1'b0);
                if (ch == 0 && k == 3) check("t1_not_valid_before_5th", NW'(out_valid), NW'(0));
                if (ch == 0 && k == 4) begin
                    check("t1_valid_after_5th", NW'(out_valid), NW'(1));
                    check("t1_beat0_data", out_data, 80'h0000_0001_0002_0003_0004);
                    check("t1_beat0_sof", NW'(out_sof), NW'(1));
                end
                if (ch == 31 && k == 4) begin
                    check("t1_beat31_chno", NW'(out_chno), NW'(31));
                    check("t1_beat31_data", out_data, 80'h01F0_01F1_01F2_01F3_01F4);
                end
            end
        end
        step('0, '0, 1'b0, 1'b1, 1'b0);
        check("t1_beats", NW'(dut_beats), NW'(32));
        check("t1_chno_wrap", NW'(out_chno), NW'(0));

        // backpressure: 17 writes into a 16-deep stream 0
        do_reset('1);
        for (int i = 0; i < 17; i++) step(5'b00001, W'(16'h0100 + i), i == 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b0, 1'b0);
        check("t2_ovf_flag", NW'(ovf_flag), NW'(5'b00001));
`ifdef RAW_COMB_RESYNC_EN
        check("t3_flushed", NW'(out_valid), NW'(0));
        step(5'b00010, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        step(5'b00001, 16'hA000, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < N; k++) step(N'(1 << k), W'(16'hA000 + k), 1'b0, 1'b0, 1'b0);
        check("t3_realigned_data", out_data, 80'hA000_A001_A002_A003_A004);
        check("t3_realigned_chno", NW'(out_chno), NW'(0));
        check("t3_realigned_sof", NW'(out_sof), NW'(1));
`else
        for (int k = 1; k < N; k++)
            for (int i = 0; i < 16; i++) step(N'(1 << k), W'(k * 256 + i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step('0, '0, 1'b0, 1'b1, 1'b0);
        check("t2_beats", NW'(dut_beats), NW'(16));
`endif

        // multi-hot strobe, then clear
        do_reset('1);
        step(5'b00011, 16'h0007, 1'b0, 1'b1, 1'b0);
        check("t4_onehot_err", NW'(onehot_err), NW'(1));
        step('0, '0, 1'b0, 1'b1, 1'b1);
        check("t4_onehot_clr", NW'(onehot_err), NW'(0));
        for (int k = 0; k < N; k++) step(N'(1 << k), W'(16'h0011 * (k + 1)), 1'b0, 1'b0, 1'b0);
        check("t4_no_stray_write", out_data, 80'h0011_0022_0033_0044_0055);

        // partial enable mask
        do_reset(5'b10101);
        step(5'b00010, 16'hDDDD, 1'b0, 1'b0, 1'b0);
        step(5'b00001, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        step(5'b00100, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        step(5'b10000, 16'hCCCC, 1'b0, 1'b0, 1'b0);
        check("t5_valid", NW'(out_valid), NW'(1));
        check("t5_data", out_data, 80'hAAAA_0000_BBBB_0000_CCCC);

        // randomized traffic
        for (int seg = 0; seg < 6; seg++) begin
            en = (seg == 0) ? '1 : N'($urandom_range(1, 31));
            do_reset(en);
            for (int i = 0; i < 400; i++) begin
                r = $urandom_range(0, 19);
                if (r < 16)      sn = N'(1 << (r % N));
                else if (r < 18) sn = '0;
                else             sn = N'($urandom_range(0, 31));
                step(sn, W'($urandom_range(0, 65535)), $urandom_range(0, 7) == 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
            end
        end

        // asynchronous reset while a beat is pending
        do_reset('1);
        for (int k = 0; k < N; k++) step(N'(1 << k), W'(k + 1), 1'b0, 1'b0, 1'b0);
        step(5'b00110, '0, 1'b0, 1'b0, 1'b0);
        check("t6_valid_before_reset", NW'(out_valid), NW'(1));
        #2;
        do_reset('1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
